// File: rtl/dispense_arbiter_if.sv
// Booth/dispenser bundle for the dispense arbiter.
// The slave modport is the arbiter, the master modport is the booth/dispenser side.
interface dispense_arbiter_if #(
    parameter int NUM_BOOTHS = 4,
    parameter int CNT_W      = 8,
    parameter int CHG_W      = 8
);
    logic [NUM_BOOTHS-1:0]       req;
    logic [NUM_BOOTHS*CNT_W-1:0] tkt_cnt;
    logic [NUM_BOOTHS*CHG_W-1:0] chg_amt;
    logic                        printer_rdy;
    logic                        hopper_rdy;
    logic [NUM_BOOTHS-1:0]       grant;
    logic [NUM_BOOTHS-1:0]       ack;
    logic                        ticket;
    logic                        one_output;
    logic                        busy;

    // Handshake: the booth holds req until it sees ack. printer_rdy and hopper_rdy
    // are sampled at the edge that starts a cycle. A ticket or one_output pulse in
    // that cycle is one dispensed unit, and the dispenser must accept it.
    modport slave (
        input  req, tkt_cnt, chg_amt, printer_rdy, hopper_rdy,
        output grant, ack, ticket, one_output, busy
    );

    modport master (
        output req, tkt_cnt, chg_amt, printer_rdy, hopper_rdy,
        input  grant, ack, ticket, one_output, busy
    );
endinterface

// File: rtl/dispense_arbiter.sv
// Round-robin arbiter that shares one ticket printer and one coin hopper between booths.
// It grants a booth, then pulses once per ticket and once per change unit, then acks.
module dispense_arbiter #(
    parameter int NUM_BOOTHS = 4,
    parameter int CNT_W      = 8,
    parameter int CHG_W      = 8
) (
    input  logic                clk,
    input  logic                rst,
    dispense_arbiter_if.slave   io_bus,
    output logic [2:0]          o_dbg_state
);
    localparam int PTR_W = (NUM_BOOTHS > 1) ? $clog2(NUM_BOOTHS) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_TICKET = 3'd1,
        S_TGAP   = 3'd2,
        S_COIN   = 3'd3,
        S_CGAP   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [PTR_W-1:0]      r_ptr;
    logic [PTR_W-1:0]      w_sel;
    logic [PTR_W-1:0]      w_idx;
    logic                  w_found;
    logic [NUM_BOOTHS-1:0] r_grant;
    logic [NUM_BOOTHS-1:0] r_ack;
    logic [NUM_BOOTHS-1:0] w_grant_next;
    logic                  r_ticket;
    logic                  r_one;
    logic                  r_busy;
    logic [CNT_W-1:0]      r_tkt_left;
    logic [CHG_W-1:0]      r_chg_left;
    logic [CNT_W-1:0]      w_tkt_sel;
    logic [CHG_W-1:0]      w_chg_sel;

    // Scan from farthest to nearest so that the nearest requester after ptr is kept.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        for (int k = NUM_BOOTHS; k >= 1; k--) begin
            w_idx = PTR_W'((int'(r_ptr) + k) % NUM_BOOTHS);
            if (io_bus.req[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    assign w_tkt_sel = io_bus.tkt_cnt[int'(w_sel)*CNT_W +: CNT_W];
    assign w_chg_sel = io_bus.chg_amt[int'(w_sel)*CHG_W +: CHG_W];

    // A pulse is issued on entry to TICKET/COIN, so the state leaves once the pulse is seen.
    always_comb begin
        w_next       = r_state;
        w_grant_next = r_grant;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_grant_next = {{(NUM_BOOTHS-1){1'b0}}, 1'b1} << w_sel;
                    if (w_tkt_sel != '0)      w_next = S_TICKET;
                    else if (w_chg_sel != '0) w_next = S_COIN;
                    else                      w_next = S_DONE;
                end
            end
            S_TICKET: if (r_ticket) w_next = S_TGAP;
            S_TGAP: begin
                if (r_tkt_left != '0)      w_next = S_TICKET;
                else if (r_chg_left != '0) w_next = S_COIN;
                else                       w_next = S_DONE;
            end
            S_COIN: if (r_one) w_next = S_CGAP;
            S_CGAP: begin
                if (r_chg_left != '0) w_next = S_COIN;
                else                  w_next = S_DONE;
            end
            S_DONE: begin
                w_next       = S_IDLE;
                w_grant_next = '0;
            end
            default: begin
                w_next       = S_IDLE;
                w_grant_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ptr      <= PTR_W'(NUM_BOOTHS - 1);
            r_grant    <= '0;
            r_ack      <= '0;
            r_ticket   <= 1'b0;
            r_one      <= 1'b0;
            r_busy     <= 1'b0;
            r_tkt_left <= '0;
            r_chg_left <= '0;
        end else begin
            r_state  <= w_next;
            r_grant  <= w_grant_next;
            r_ack    <= (w_next == S_DONE) ? w_grant_next : '0;
            r_ticket <= (w_next == S_TICKET) && io_bus.printer_rdy;
            r_one    <= (w_next == S_COIN) && io_bus.hopper_rdy;
            r_busy   <= (w_next != S_IDLE);
            if (r_state == S_IDLE && w_found) begin
                r_ptr      <= w_sel;
                r_tkt_left <= w_tkt_sel;
                r_chg_left <= w_chg_sel;
            end
            if (r_state == S_TICKET && r_ticket && r_tkt_left != '0)
                r_tkt_left <= r_tkt_left - CNT_W'(1);
            if (r_state == S_COIN && r_one && r_chg_left != '0)
                r_chg_left <= r_chg_left - CHG_W'(1);
        end
    end

    assign io_bus.grant      = r_grant;
    assign io_bus.ack        = r_ack;
    assign io_bus.ticket     = r_ticket;
    assign io_bus.one_output = r_one;
    assign io_bus.busy       = r_busy;
    assign o_dbg_state       = r_state;
endmodule

// File: tb/tb_dispense_arbiter.sv
// Directed bench for dispense_arbiter with hand-computed cycle-by-cycle expectations.
// Cycle n is the interval after the n-th rising edge, counted from the edge that samples req.
module tb_dispense_arbiter;
    logic clk;
    logic rst;
    logic [2:0] dbg_state;
    int checks;
    int errors;

    dispense_arbiter_if #(.NUM_BOOTHS(4), .CNT_W(8), .CHG_W(8)) bus_if ();

    dispense_arbiter #(.NUM_BOOTHS(4), .CNT_W(8), .CHG_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .io_bus      (bus_if),
        .o_dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] g, input logic [3:0] a,
                           input logic t, input logic o, input logic b);
        chk({tag, " grant"},      bus_if.grant, g);
        chk({tag, " ack"},        bus_if.ack, a);
        chk({tag, " ticket"},     bus_if.ticket, t);
        chk({tag, " one_output"}, bus_if.one_output, o);
        chk({tag, " busy"},       bus_if.busy, b);
    endtask

    task automatic set_booth(input int b, input logic [7:0] t, input logic [7:0] c);
        bus_if.tkt_cnt[b*8 +: 8] = t;
        bus_if.chg_amt[b*8 +: 8] = c;
    endtask

    initial begin
        logic [3:0] exp_g [5];
        int n_tkt;
        int n_one;
        int n_both;
        int n;
        logic seen;

        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus_if.req = '0;
        bus_if.tkt_cnt = '0;
        bus_if.chg_amt = '0;
        bus_if.printer_rdy = 1'b1;
        bus_if.hopper_rdy = 1'b1;
        tick();
        tick();
        chk_out("reset", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        chk("reset state", dbg_state, 3'd0);
        rst = 1'b0;
        tick();

        // 1: booth0 with 3 tickets and 1 coin
        set_booth(0, 8'd3, 8'd1);
        bus_if.req = 4'b0001;
        tick();
        bus_if.req = '0;
        for (int c = 1; c <= 10; c++) begin
            chk_out($sformatf("t1 c%0d", c), (c <= 9) ? 4'h1 : 4'h0, (c == 9) ? 4'h1 : 4'h0,
                    (c == 1 || c == 3 || c == 5), (c == 7), (c <= 9));
            if (c < 10) tick();
        end

        // 2: booth1 with nothing to dispense
        set_booth(1, 8'd0, 8'd0);
        bus_if.req = 4'b0010;
        tick();
        bus_if.req = '0;
        chk_out("t2 c1", 4'h2, 4'h2, 1'b0, 1'b0, 1'b1);
        tick();
        chk_out("t2 c2", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);

        // 3: all booths request with zero counts, starting from a fresh pointer
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus_if.tkt_cnt = '0;
        bus_if.chg_amt = '0;
        bus_if.req = 4'b1111;
        exp_g[0] = 4'h1; exp_g[1] = 4'h2; exp_g[2] = 4'h4; exp_g[3] = 4'h8; exp_g[4] = 4'h1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_out($sformatf("t3 g%0d", i), exp_g[i], exp_g[i], 1'b0, 1'b0, 1'b1);
            if (i == 4) bus_if.req = '0;
            tick();
            chk_out($sformatf("t3 idle%0d", i), 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        end

        // 4: booth2, 2 tickets, printer not ready for cycles 1..5
        set_booth(2, 8'd2, 8'd0);
        bus_if.printer_rdy = 1'b0;
        bus_if.req = 4'b0100;
        tick();
        bus_if.req = '0;
        for (int c = 1; c <= 11; c++) begin
            chk_out($sformatf("t4 c%0d", c), (c <= 10) ? 4'h4 : 4'h0, (c == 10) ? 4'h4 : 4'h0,
                    (c == 6 || c == 8), 1'b0, (c <= 10));
            if (c == 5) bus_if.printer_rdy = 1'b1;
            if (c < 11) tick();
        end

        // 5: round-robin order after booth1 with new requests arriving mid-service
        set_booth(1, 8'd1, 8'd0);
        bus_if.req = 4'b0010;
        tick();
        bus_if.req = '0;
        chk_out("t5 c1", 4'h2, 4'h0, 1'b1, 1'b0, 1'b1);
        tick();
        chk_out("t5 c2", 4'h2, 4'h0, 1'b0, 1'b0, 1'b1);
        bus_if.req = 4'b0101;
        set_booth(2, 8'd0, 8'd1);
        set_booth(0, 8'd0, 8'd0);
        tick();
        chk_out("t5 c3", 4'h2, 4'h2, 1'b0, 1'b0, 1'b1);
        tick();
        chk_out("t5 c4", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_out("t5 c5", 4'h4, 4'h0, 1'b0, 1'b1, 1'b1);
        bus_if.req = 4'b0001;
        tick();
        chk_out("t5 c6", 4'h4, 4'h0, 1'b0, 1'b0, 1'b1);
        tick();
        chk_out("t5 c7", 4'h4, 4'h4, 1'b0, 1'b0, 1'b1);
        tick();
        chk_out("t5 c8", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_out("t5 c9", 4'h1, 4'h1, 1'b0, 1'b0, 1'b1);
        bus_if.req = '0;
        tick();
        chk_out("t5 c10", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);

        // Full scale: booth3 with 255 tickets and 255 coins; counts change after grant
        set_booth(3, 8'hFF, 8'hFF);
        bus_if.req = 4'b1000;
        tick();
        bus_if.req = '0;
        set_booth(3, 8'd1, 8'd1);
        chk("fs grant", bus_if.grant, 4'h8);
        n_tkt = 0; n_one = 0; n_both = 0; n = 0; seen = 1'b0;
        while (!seen && n < 3000) begin
            if (bus_if.ticket) n_tkt++;
            if (bus_if.one_output) n_one++;
            if (bus_if.ticket && bus_if.one_output) n_both++;
            if (bus_if.ack != '0) begin
                seen = 1'b1;
                chk("fs ack", bus_if.ack, 4'h8);
            end else begin
                tick();
                n++;
            end
        end
        chk("fs ack seen", seen, 1'b1);
        chk("fs tickets", n_tkt, 255);
        chk("fs coins", n_one, 255);
        chk("fs overlap", n_both, 0);
        tick();
        chk_out("fs idle", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);

        // 6: reset in mid-service drops the transaction and restores booth0 priority
        set_booth(0, 8'd3, 8'd0);
        bus_if.req = 4'b0001;
        tick();
        bus_if.req = '0;
        chk_out("t6 c1", 4'h1, 4'h0, 1'b1, 1'b0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk_out("t6 async", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        chk("t6 async state", dbg_state, 3'd0);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk_out($sformatf("t6 quiet%0d", c), 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        end
        set_booth(2, 8'd0, 8'd0);
        bus_if.req = 4'b0101;
        tick();
        bus_if.req = 4'b0100;
        chk_out("t6 r1", 4'h1, 4'h0, 1'b1, 1'b0, 1'b1);
        for (int c = 2; c <= 9; c++) begin
            tick();
            if (c <= 7)
                chk_out($sformatf("t6 r%0d", c), 4'h1, (c == 7) ? 4'h1 : 4'h0,
                        (c == 3 || c == 5), 1'b0, 1'b1);
            else if (c == 8)
                chk_out("t6 r8", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
            else begin
                chk_out("t6 r9", 4'h4, 4'h4, 1'b0, 1'b0, 1'b1);
                bus_if.req = '0;
            end
        end
        tick();
        chk_out("t6 end", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
